// File: rtl/dds_lag_check_sequencer_if.sv
// DDS channel stream feeding the lag-check sequencer: one word per cycle, qualified by in_valid.
`timescale 1ns/1ps
interface dds_lag_check_sequencer_if #(
   parameter int unsigned CH_W  = 8,
   parameter int unsigned LAG_W = 16
) ();
   logic             in_valid;
   logic [CH_W-1:0]  in_ch;
   logic [LAG_W-1:0] in_lag;

   modport master (output in_valid, in_ch, in_lag);
   modport slave  (input  in_valid, in_ch, in_lag);
endinterface

// File: rtl/dds_lag_check_sequencer.sv
// Captures the lag word of one selected DDS channel into a tagged 32-bit readback word,
// sequencing capture / hold / re-arm so software always reads a stable value.
`timescale 1ns/1ps
module dds_lag_check_sequencer #(
   parameter int unsigned CH_W        = 8,
   parameter int unsigned LAG_W       = 16,
   parameter int unsigned HOLD_CYC    = 256,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                     user_clk,
   input  logic                     user_rst,
   input  logic                     cfg_en,
   input  logic [CH_W-1:0]          cfg_ch,
   dds_lag_check_sequencer_if.slave dds,
   output logic [31:0]              reg_data,
   output logic                     capture_strobe,
   output logic                     busy
);
   localparam int unsigned HOLD_W = $clog2(HOLD_CYC);
   localparam int unsigned SEEK_W = $clog2(TIMEOUT_CYC);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [SEEK_W-1:0] SEEK_LAST = SEEK_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, SEEK, HOLD} state_t;

   state_t            state_q,    state_d;
   logic [CH_W-1:0]   ch_lat_q,   ch_lat_d;
   logic [SEEK_W-1:0] seek_cnt_q, seek_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              valid_q,    valid_d;
   logic              tout_q,     tout_d;
   logic [5:0]        seq_q,      seq_d;
   logic [23:0]       lag_q,      lag_d;
   logic              strobe_q,   strobe_d;
   logic              busy_q,     busy_d;

   logic match;
   logic ch_change;

   always_comb begin
      state_d    = state_q;
      ch_lat_d   = ch_lat_q;
      seek_cnt_d = seek_cnt_q;
      hold_cnt_d = hold_cnt_q;
      valid_d    = valid_q;
      tout_d     = tout_q;
      seq_d      = seq_q;
      lag_d      = lag_q;
      strobe_d   = 1'b0;

      match     = dds.in_valid && (dds.in_ch == ch_lat_q);
      ch_change = (cfg_ch != ch_lat_q);

      // A channel change outranks a match: a word matching the old channel is stale.
      if (!cfg_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = SEEK;
               ch_lat_d   = cfg_ch;
               seek_cnt_d = '0;
            end
            SEEK: begin
               if (ch_change) begin
                  ch_lat_d   = cfg_ch;
                  valid_d    = 1'b0;
                  tout_d     = 1'b0;
                  seek_cnt_d = '0;
               end else if (match) begin
                  lag_d      = 24'(dds.in_lag);
                  valid_d    = 1'b1;
                  tout_d     = 1'b0;
                  seq_d      = seq_q + 6'd1;
                  strobe_d   = 1'b1;
                  hold_cnt_d = '0;
                  state_d    = HOLD;
               end else if (seek_cnt_q == SEEK_LAST) begin
                  valid_d    = 1'b0;
                  tout_d     = 1'b1;
                  seek_cnt_d = '0;
               end else begin
                  seek_cnt_d = seek_cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (ch_change) begin
                  ch_lat_d   = cfg_ch;
                  valid_d    = 1'b0;
                  tout_d     = 1'b0;
                  seek_cnt_d = '0;
                  state_d    = SEEK;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  seek_cnt_d = '0;
                  state_d    = SEEK;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q    <= IDLE;
         ch_lat_q   <= '0;
         seek_cnt_q <= '0;
         hold_cnt_q <= '0;
         valid_q    <= 1'b0;
         tout_q     <= 1'b0;
         seq_q      <= '0;
         lag_q      <= '0;
         strobe_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_lat_q   <= ch_lat_d;
         seek_cnt_q <= seek_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         valid_q    <= valid_d;
         tout_q     <= tout_d;
         seq_q      <= seq_d;
         lag_q      <= lag_d;
         strobe_q   <= strobe_d;
         busy_q     <= busy_d;
      end
   end

   assign reg_data       = {valid_q, tout_q, seq_q, lag_q};
   assign capture_strobe = strobe_q;
   assign busy           = busy_q;

   strobe_single_cycle: assert property (@(posedge user_clk) disable iff (user_rst)
      capture_strobe |=> !capture_strobe);
endmodule

// File: tb/tb_dds_lag_check_sequencer.sv
// Directed scenarios plus a randomized phase, every cycle checked against a timestamp-based model.
`timescale 1ns/1ps
module tb_dds_lag_check_sequencer;
   localparam int unsigned CH_W        = 9;
   localparam int unsigned LAG_W       = 16;
   localparam int unsigned HOLD_CYC    = 256;
   localparam int unsigned TIMEOUT_CYC = 1024;

   logic              user_clk = 1'b0;
   logic              user_rst;
   logic              cfg_en;
   logic [CH_W-1:0]   cfg_ch;
   logic [31:0]       reg_data;
   logic              capture_strobe;
   logic              busy;

   dds_lag_check_sequencer_if #(.CH_W(CH_W), .LAG_W(LAG_W)) strm ();

   dds_lag_check_sequencer #(
      .CH_W(CH_W), .LAG_W(LAG_W), .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .user_clk(user_clk), .user_rst(user_rst), .cfg_en(cfg_en), .cfg_ch(cfg_ch),
      .dds(strm), .reg_data(reg_data), .capture_strobe(capture_strobe), .busy(busy)
   );

   always #5 user_clk = ~user_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: time-stamped phases instead of counters.
   typedef enum {M_IDLE, M_SEEK, M_HOLD} mmode_t;
   mmode_t  m_mode   = M_IDLE;
   int      m_ch     = 0;
   longint  cyc      = 0;
   longint  seek_t0  = 0;
   longint  hold_t0  = 0;
   bit      m_valid  = 0;
   bit      m_to     = 0;
   bit      m_strobe = 0;
   int      m_seq    = 0;
   int      m_lag    = 0;

   int unsigned sidx = 0;
   int          last_lag = 0;

   function automatic void model_edge();
      m_strobe = 0;
      if (user_rst) begin
         m_mode = M_IDLE; m_ch = 0; m_valid = 0; m_to = 0; m_seq = 0; m_lag = 0;
      end else if (!cfg_en) begin
         m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
         m_mode = M_SEEK; m_ch = int'(cfg_ch); seek_t0 = cyc + 1;
      end else if (int'(cfg_ch) != m_ch) begin
         m_ch = int'(cfg_ch); m_valid = 0; m_to = 0; m_mode = M_SEEK; seek_t0 = cyc + 1;
      end else if (m_mode == M_SEEK) begin
         if (strm.in_valid && int'(strm.in_ch) == m_ch) begin
            m_lag = int'(strm.in_lag); m_valid = 1; m_to = 0; m_seq++;
            m_strobe = 1; m_mode = M_HOLD; hold_t0 = cyc + 1;
         end else if ((cyc - seek_t0) % TIMEOUT_CYC == TIMEOUT_CYC - 1) begin
            m_to = 1; m_valid = 0;
         end
      end else if (cyc - hold_t0 == HOLD_CYC - 1) begin
         m_mode = M_SEEK; seek_t0 = cyc + 1;
      end
      cyc++;
   endfunction

   function automatic logic [31:0] exp_reg();
      return {m_valid, m_to, 6'(m_seq % 64), 24'(m_lag)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge user_clk);
      model_edge();
      @(negedge user_clk);
      check("reg_data", reg_data, exp_reg());
      check("capture_strobe", {31'b0, capture_strobe}, {31'b0, m_strobe});
      check("busy", {31'b0, busy}, {31'b0, m_mode != M_IDLE});
   endtask

   // mode 0: sweep ch 0..255 lag=ch*3; 1: cfg channel, random lag; 2: ch 5/7 alternating; else idle
   task automatic drive_word(input int mode);
      int ch;
      strm.in_valid = 1'b1;
      case (mode)
         0: ch = int'(sidx % 256);
         1: ch = int'(cfg_ch);
         2: ch = (sidx % 2 == 0) ? 5 : 7;
         default: begin ch = 0; strm.in_valid = 1'b0; end
      endcase
      strm.in_ch  = CH_W'(ch);
      strm.in_lag = (mode == 1) ? LAG_W'($urandom) : LAG_W'(ch * 3);
      last_lag    = int'(strm.in_lag);
      sidx++;
   endtask

   task automatic drive_until_strobe(input int mode, input int budget, output int n, output bit got);
      got = 0;
      n   = 0;
      while (!got && n < budget) begin
         drive_word(mode);
         tick();
         n++;
         if (capture_strobe) got = 1;
      end
      check("strobe_wait", {31'b0, got}, 32'd1);
   endtask

   int n;
   bit got;
   int strobes;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      user_rst = 1'b1; cfg_en = 1'b0; cfg_ch = '0;
      strm.in_valid = 1'b0; strm.in_ch = '0; strm.in_lag = '0;
      @(negedge user_clk);
      tick(); tick();
      check("reset_reg", reg_data, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'd0);

      // 1: first capture of ch5 one cycle after it is seen
      user_rst = 1'b0; cfg_en = 1'b1; cfg_ch = 9'd5; sidx = 0;
      drive_until_strobe(0, 300, n, got);
      check("t1_latency", n, 32'd6);
      check("t1_reg", reg_data, 32'h8100000F);

      // 2: ch5 seen during HOLD is ignored; next capture one sweep later
      drive_until_strobe(0, 600, n, got);
      check("t2_gap", n, 32'd512);
      check("t2_reg", reg_data, 32'h8200000F);

      // 3: unreachable channel -> timeout flag after TIMEOUT_CYC seek cycles
      cfg_ch = 9'd300;
      drive_word(0); tick();
      check("t3_change", reg_data, 32'h0200000F);
      n = 0;
      while (!reg_data[30] && n < 1100) begin drive_word(0); tick(); n++; end
      check("t3_timeout_cycles", n, 32'd1024);
      check("t3_reg", reg_data, 32'h4200000F);
      for (int i = 0; i < 1100; i++) begin drive_word(0); tick(); end
      check("t3_reg_later", reg_data, 32'h4200000F);

      // 4: 64 captures wrap the sequence field
      cfg_ch = CH_W'($urandom_range(0, 255));
      strobes = 0;
      for (int i = 0; i < 64; i++) begin
         drive_until_strobe(1, 300, n, got);
         if (got) strobes++;
         check("t4_lag", {8'h0, reg_data[23:0]}, 32'(last_lag));
      end
      check("t4_count", strobes, 32'd64);
      check("t4_reg", reg_data, {2'b10, 6'd2, 24'(last_lag)});

      // 5: switch 5->7 mid-HOLD with both channels interleaved
      cfg_ch = 9'd5;
      drive_until_strobe(2, 300, n, got);
      check("t5_ch5", reg_data, {2'b10, 6'd3, 24'd15});
      for (int i = 0; i < 10; i++) begin drive_word(2); tick(); end
      cfg_ch = 9'd7;
      drive_word(2); tick();
      check("t5_change", reg_data, {2'b00, 6'd3, 24'd15});
      drive_until_strobe(2, 300, n, got);
      check("t5_ch7", reg_data, {2'b10, 6'd4, 24'd21});

      // 6: reset mid-HOLD, then disable mid-SEEK with a matching word present
      for (int i = 0; i < 20; i++) begin drive_word(2); tick(); end
      user_rst = 1'b1;
      drive_word(2); tick();
      check("t6_rst_reg", reg_data, 32'h0);
      check("t6_rst_busy", {31'b0, busy}, 32'd0);
      user_rst = 1'b0;
      drive_until_strobe(2, 300, n, got);
      check("t6_capture", reg_data, 32'h81000015);
      for (int i = 0; i < 300; i++) begin drive_word(3); tick(); end
      check("t6_seek_busy", {31'b0, busy}, 32'd1);
      cfg_en = 1'b0;
      strm.in_valid = 1'b1; strm.in_ch = 9'd7; strm.in_lag = 16'd99;
      tick();
      check("t6_dis_busy", {31'b0, busy}, 32'd0);
      check("t6_dis_strobe", {31'b0, capture_strobe}, 32'd0);
      check("t6_dis_reg", reg_data, 32'h81000015);
      for (int i = 0; i < 5; i++) tick();

      // Randomized phase: channel changes, enable toggles, occasional reset
      cfg_en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         user_rst = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 199) == 0) cfg_en = ~cfg_en;
         if ($urandom_range(0, 99) == 0)
            cfg_ch = ($urandom_range(0, 4) == 4) ? 9'd8 : CH_W'($urandom_range(0, 3));
         strm.in_valid = $urandom_range(0, 1) == 1;
         strm.in_ch    = CH_W'($urandom_range(0, 3));
         strm.in_lag   = LAG_W'($urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
